mem_bus_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 16-bit memory bus built from `memory256x16` / `memory256x16_program` chips. It accepts word read/write requests from two masters (port 0: processor, port 1: I/O/DMA engine) and grants them with round-robin fairness. It decodes the address upper byte into per-chip enables and drives the chips' write and read condition codes and the tristate data bus. It returns registered read data with a one-cycle acknowledge.

---
 rtl/mem_bus_arbiter_if.sv | 38 +++
 rtl/mem_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Memory bus condition codes and the requester/arbiter bundle for mem_bus_arbiter.
// Both condition codes are active-low chip strobes.
package mem_bus_arbiter_pkg;
  typedef enum logic { MEM_WR = 1'b0, MEM_WR_IDLE = 1'b1 } wr_cond_code_t;
  typedef enum logic { MEM_RD = 1'b0, MEM_RD_IDLE = 1'b1 } rd_cond_code_t;
endpackage

interface mem_bus_arbiter_if #(parameter int CHIPS = 4);
  import mem_bus_arbiter_pkg::*;

  logic             req0;
  logic             req1;
  logic             wr0;
  logic             wr1;
  logic [15:0]      addr0;
  logic [15:0]      addr1;
  logic [15:0]      wdata0;
  logic [15:0]      wdata1;
  logic             ack0;
  logic             ack1;
  logic [15:0]      rdata;
  logic             err;
  logic [7:0]       mem_addr;
  logic [CHIPS-1:0] mem_en;
  wr_cond_code_t    mem_we_L;
  rd_cond_code_t    mem_re_L;

  // Requester side; the chip-side signals are visible for observation only.
  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata, err, mem_addr, mem_en, mem_we_L, mem_re_L
  );

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata, err, mem_addr, mem_en, mem_we_L, mem_re_L
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin two-master arbiter/sequencer for the shared 256x16 memory-chip bus.
// Each granted transaction runs IDLE -> ACCESS -> ACK, one cycle per state.
//
// state  | meaning
// IDLE   | bus released; sample requests and latch the round-robin winner
// ACCESS | drive chip enable and strobe; read data captured at the closing edge
// ACK    | one-cycle ack (and err) to the latched master; bus released
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int CHIPS = 4
) (
  input  logic              clock,
  input  logic              reset_L,
  mem_bus_arbiter_if.slave  bus,
  inout  wire  [15:0]       mem_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic          last;
  logic          sel;
  logic          wr_q;
  logic [15:0]   addr_q;
  logic [15:0]   wdata_q;
  logic          err_q;
  logic [15:0]   rdata_q;

  logic          any_req;
  logic          grant;
  logic          in_range;

  logic [CHIPS-1:0] mem_en_c;
  logic [7:0]       mem_addr_c;
  wr_cond_code_t    mem_we_c;
  rd_cond_code_t    mem_re_c;
  logic             drive_c;
  logic             ack0_c;
  logic             ack1_c;
  logic             err_c;

  assign any_req  = bus.req0 | bus.req1;
  // With both masters asking, the one that did not win last time goes next.
  assign grant    = (bus.req0 & bus.req1) ? ~last : bus.req1;
  assign in_range = addr_q[15:8] < 8'(CHIPS);

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_en_c   = '0;
    mem_addr_c = '0;
    mem_we_c   = MEM_WR_IDLE;
    mem_re_c   = MEM_RD_IDLE;
    drive_c    = 1'b0;
    ack0_c     = 1'b0;
    ack1_c     = 1'b0;
    err_c      = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt  = ACK;
        mem_addr_c = addr_q[7:0];
        // Out-of-range addresses touch no chip and never strobe the bus.
        if (in_range) begin
          for (int k = 0; k < CHIPS; k++) begin
            mem_en_c[k] = (addr_q[15:8] == 8'(k));
          end
          if (wr_q) begin
            mem_we_c = MEM_WR;
            drive_c  = 1'b1;
          end else begin
            mem_re_c = MEM_RD;
          end
        end
      end
      ACK: begin
        state_nxt = IDLE;
        ack0_c    = ~sel;
        ack1_c    = sel;
        err_c     = err_q;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      last    <= 1'b1;
      sel     <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        sel     <= grant;
        last    <= grant;
        wr_q    <= grant ? bus.wr1    : bus.wr0;
        addr_q  <= grant ? bus.addr1  : bus.addr0;
        wdata_q <= grant ? bus.wdata1 : bus.wdata0;
      end
      if (state == ACCESS) begin
        err_q <= ~in_range;
        if (!in_range) begin
          rdata_q <= 16'hFFFF;
        end else if (!wr_q) begin
          rdata_q <= mem_data;
        end
      end
    end
  end

  assign mem_data     = drive_c ? wdata_q : 16'hzzzz;
  assign bus.mem_en   = mem_en_c;
  assign bus.mem_addr = mem_addr_c;
  assign bus.mem_we_L = mem_we_c;
  assign bus.mem_re_L = mem_re_c;
  assign bus.ack0     = ack0_c;
  assign bus.ack1     = ack1_c;
  assign bus.err      = err_c;
  assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with a 4-chip memory model on a pulled-up bus.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic [15:0] exp_bus;
    logic        exp_err;
    logic [3:0]  exp_en;
    int          rel;
    int          exp_cyc;
  } txn_t;

  logic clock;
  logic reset_L;
  tri1 [15:0] mem_data;

  mem_bus_arbiter_if #(.CHIPS(4)) bus ();

  mem_bus_arbiter #(.CHIPS(4)) dut (
    .clock    (clock),
    .reset_L  (reset_L),
    .bus      (bus),
    .mem_data (mem_data)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base_cyc = 0;

  txn_t s0[$];
  txn_t s1[$];
  txn_t sb0[$];
  txn_t sb1[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Memory model: 4 chips x 256 words, combinational read, write at clock edge
  logic [15:0] mem [0:1023];
  logic        mem_clear;
  logic [9:0]  midx;
  logic        mhit;
  logic        mem_drive;

  always_comb begin
    midx = {2'b00, bus.mem_addr};
    mhit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (bus.mem_en[k]) begin
        midx = 10'(k * 256) + {2'b00, bus.mem_addr};
        mhit = 1'b1;
      end
    end
  end

  assign mem_drive = mhit && (bus.mem_re_L == MEM_RD);
  assign mem_data  = mem_drive ? mem[midx] : 16'hzzzz;

  always @(posedge clock) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
    end else if (mhit && bus.mem_we_L == MEM_WR) begin
      mem[midx] <= mem_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic stim(input bit port, input logic wr, input logic [15:0] addr,
                      input logic [15:0] wdata, input logic [15:0] exp_rdata,
                      input logic [15:0] exp_bus, input logic exp_err,
                      input logic [3:0] exp_en, input int rel);
    txn_t t;
    t.wr = wr; t.addr = addr; t.wdata = wdata; t.exp_rdata = exp_rdata;
    t.exp_bus = exp_bus; t.exp_err = exp_err; t.exp_en = exp_en;
    t.rel = rel; t.exp_cyc = 0;
    if (port) s1.push_back(t);
    else      s0.push_back(t);
  endtask

  // Holds req across back-to-back transactions; drops it at the last ack.
  task automatic run_master(input bit port);
    txn_t t;
    bit   got;
    int   n;
    n = port ? s1.size() : s0.size();
    for (int i = 0; i < n; i++) begin
      t = port ? s1.pop_front() : s0.pop_front();
      t.exp_cyc = base_cyc + t.rel;
      if (port) begin
        bus.wr1 = t.wr; bus.addr1 = t.addr; bus.wdata1 = t.wdata; bus.req1 = 1'b1;
        sb1.push_back(t);
      end else begin
        bus.wr0 = t.wr; bus.addr0 = t.addr; bus.wdata0 = t.wdata; bus.req0 = 1'b1;
        sb0.push_back(t);
      end
      got = 1'b0;
      for (int k = 0; k < 30 && !got; k++) begin
        @(negedge clock);
        got = port ? bus.ack1 : bus.ack0;
      end
      chk($sformatf("p%0d ack_seen addr=%04h", port, t.addr), 32'(got), 32'd1);
    end
    if (port) bus.req1 = 1'b0;
    else      bus.req0 = 1'b0;
  endtask

  task automatic run_both();
    base_cyc = cyc;
    fork
      run_master(1'b0);
      run_master(1'b1);
    join
    repeat (2) @(negedge clock);
  endtask

  logic [3:0]  prev_en;
  logic        prev_we;
  logic        prev_re;
  logic [15:0] prev_data;

  always @(negedge clock) begin : monitor
    txn_t  e;
    logic  p;
    string tag;
    if (reset_L) begin
      if (!mem_drive && bus.mem_we_L != MEM_WR)
        chk("bus_released", 32'(mem_data), 32'h0000FFFF);
      if (bus.ack0 || bus.ack1) begin
        chk("ack_onehot", 32'(bus.ack0 & bus.ack1), 32'd0);
        p   = bus.ack1;
        tag = p ? "p1" : "p0";
        chk({tag, " ack_expected"}, 32'((p ? sb1.size() : sb0.size()) > 0), 32'd1);
        if ((p ? sb1.size() : sb0.size()) > 0) begin
          e   = p ? sb1.pop_front() : sb0.pop_front();
          tag = $sformatf("p%0d %s %04h", p, e.wr ? "wr" : "rd", e.addr);
          chk({tag, " ack_cycle"}, 32'(cyc),       32'(e.exp_cyc));
          chk({tag, " rdata"},     32'(bus.rdata), 32'(e.exp_rdata));
          chk({tag, " err"},       32'(bus.err),   32'(e.exp_err));
          chk({tag, " mem_en"},    32'(prev_en),   32'(e.exp_en));
          chk({tag, " we"},        32'(prev_we),   32'(e.wr && e.exp_en != 4'd0));
          chk({tag, " re"},        32'(prev_re),   32'(!e.wr && e.exp_en != 4'd0));
          chk({tag, " bus_data"},  32'(prev_data), 32'(e.exp_bus));
        end
      end
    end
    prev_en   <= bus.mem_en;
    prev_we   <= (bus.mem_we_L == MEM_WR);
    prev_re   <= (bus.mem_re_L == MEM_RD);
    prev_data <= mem_data;
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ack0"},     32'(bus.ack0),                 32'd0);
    chk({tag, " ack1"},     32'(bus.ack1),                 32'd0);
    chk({tag, " err"},      32'(bus.err),                  32'd0);
    chk({tag, " rdata"},    32'(bus.rdata),                32'd0);
    chk({tag, " mem_en"},   32'(bus.mem_en),               32'd0);
    chk({tag, " mem_addr"}, 32'(bus.mem_addr),             32'd0);
    chk({tag, " we"},       32'(bus.mem_we_L == MEM_WR),   32'd0);
    chk({tag, " re"},       32'(bus.mem_re_L == MEM_RD),   32'd0);
    chk({tag, " mem_data"}, 32'(mem_data),                 32'h0000FFFF);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish by 100000");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    reset_L = 1'b0; mem_clear = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.wr0 = 1'b0; bus.wr1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    repeat (2) @(negedge clock);
    chk_reset_outputs("reset");
    mem_clear = 1'b0;
    reset_L = 1'b1;
    @(negedge clock);

    // Master 0 alone: write then read back, 3 cycles apart
    stim(0, 1, 16'h0012, 16'hBEEF, 16'h0000, 16'hBEEF, 0, 4'b0001, 2);
    stim(0, 0, 16'h0012, 16'h0000, 16'hBEEF, 16'hBEEF, 0, 4'b0001, 5);
    run_both();

    // Fresh reset so master 0 wins the tie
    reset_L = 1'b0; @(negedge clock); reset_L = 1'b1; @(negedge clock);
    stim(0, 1, 16'h0105, 16'h1111, 16'h0000, 16'h1111, 0, 4'b0010, 2);
    stim(1, 0, 16'h0105, 16'h0000, 16'h1111, 16'h1111, 0, 4'b0010, 5);
    run_both();

    // Both held for six transactions: grants alternate 0,1,0,1,0,1
    stim(0, 1, 16'h0210, 16'hA001, 16'h1111, 16'hA001, 0, 4'b0100, 2);
    stim(1, 0, 16'h0105, 16'h0000, 16'h1111, 16'h1111, 0, 4'b0010, 5);
    stim(0, 1, 16'h0310, 16'hA002, 16'h1111, 16'hA002, 0, 4'b1000, 8);
    stim(1, 0, 16'h0210, 16'h0000, 16'hA001, 16'hA001, 0, 4'b0100, 11);
    stim(0, 1, 16'h0010, 16'hA003, 16'hA001, 16'hA003, 0, 4'b0001, 14);
    stim(1, 0, 16'h0310, 16'h0000, 16'hA002, 16'hA002, 0, 4'b1000, 17);
    run_both();

    // Out-of-range accesses, then normal reads
    stim(0, 0, 16'h0400, 16'h0000, 16'hFFFF, 16'hFFFF, 1, 4'b0000, 2);
    stim(0, 1, 16'h0400, 16'h5555, 16'hFFFF, 16'hFFFF, 1, 4'b0000, 5);
    stim(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0001, 8);
    stim(0, 0, 16'h0012, 16'h0000, 16'hBEEF, 16'hBEEF, 0, 4'b0001, 11);
    run_both();

    // Reset in the middle of a write ACCESS
    bus.wr0 = 1'b1; bus.addr0 = 16'h0200; bus.wdata0 = 16'h7777; bus.req0 = 1'b1;
    @(posedge clock);
    #2;
    chk("access mem_en", 32'(bus.mem_en), 32'b0100);
    chk("access we",     32'(bus.mem_we_L == MEM_WR), 32'd1);
    chk("access data",   32'(mem_data), 32'h7777);
    reset_L = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    bus.req0 = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset_outputs("held_reset");
    reset_L = 1'b1;
    @(negedge clock);

    stim(1, 0, 16'h0012, 16'h0000, 16'hBEEF, 16'hBEEF, 0, 4'b0001, 2);
    run_both();

    repeat (3) @(negedge clock);
    chk("sb0_drained", 32'(sb0.size()), 32'd0);
    chk("sb1_drained", 32'(sb1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
